// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a UART transmitter: grants one byte at a time,
// strobes it into the transmitter and tracks the frame through the transmitter's busy flag.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [7:0]       i_data0,
    input  logic [7:0]       i_data1,
    output logic [1:0]       o_ack,
    output logic [7:0]       o_P_DATA,
    output logic             o_Data_Valid,
    input  logic             i_busy,
    output logic             o_grant_id,
    output logic             o_active,
    output logic             o_err,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [1:0]       o_dbg_state
);

    // Handshake: i_req[n] is held with i_data<n> stable until o_ack[n] pulses for one cycle;
    // that same cycle o_Data_Valid loads o_P_DATA into the transmitter, which answers with i_busy.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    state_t            state_q;
    logic [1:0]        ack_q;
    logic [7:0]        p_data_q;
    logic              dv_q;
    logic              gid_q;
    logic              active_q;
    logic              err_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [TW-1:0]     tmo_q;
    logic              last_gnt_q;

    logic              win_d;
    logic [7:0]        byte_d;

    // On a tie the requester that did not own the previous frame wins.
    always_comb begin
        win_d  = i_req[1] & (~i_req[0] | ~last_gnt_q);
        byte_d = win_d ? i_data1 : i_data0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            p_data_q    <= '0;
            dv_q        <= 1'b0;
            gid_q       <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            tmo_q       <= '0;
            last_gnt_q  <= 1'b1;
        end else begin
            ack_q <= '0;
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!i_busy && (i_req != 2'b00)) begin
                        state_q  <= LOAD;
                        p_data_q <= byte_d;
                        gid_q    <= win_d;
                        dv_q     <= 1'b1;
                        ack_q    <= win_d ? 2'b10 : 2'b01;
                        active_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= WAIT_BUSY;
                    tmo_q   <= '0;
                end
                WAIT_BUSY: begin
                    if (i_busy) begin
                        state_q <= WAIT_DONE;
                        tmo_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        // Transmitter never took the byte: abandon the frame uncounted.
                        state_q    <= IDLE;
                        err_q      <= 1'b1;
                        active_q   <= 1'b0;
                        tmo_q      <= '0;
                        last_gnt_q <= gid_q;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!i_busy) begin
                        state_q     <= IDLE;
                        active_q    <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        last_gnt_q  <= gid_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ack        = ack_q;
    assign o_P_DATA     = p_data_q;
    assign o_Data_Valid = dv_q;
    assign o_grant_id   = gid_q;
    assign o_active     = active_q;
    assign o_err        = err_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single, tie, timeout, external busy, mid-frame reset
// and frame-counter wrap, checked through a load/count scoreboard plus direct checks.
module tb_uart_tx_arbiter;

    localparam int TMO = 16;
    localparam int CW  = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [1:0]    i_req;
    logic [7:0]    i_data0;
    logic [7:0]    i_data1;
    logic          i_busy;
    logic [1:0]    o_ack;
    logic [7:0]    o_P_DATA;
    logic          o_Data_Valid;
    logic          o_grant_id;
    logic          o_active;
    logic          o_err;
    logic [CW-1:0] o_frame_cnt;
    logic [1:0]    o_dbg_state;

    int checks = 0;
    int errors = 0;

    // Load entries are {ack, grant_id, byte}.
    logic [10:0]   exp_q[$];
    logic [CW-1:0] exp_cnt_q[$];
    logic [CW-1:0] exp_frames;
    logic [CW-1:0] prev_cnt;
    logic [10:0]   mon_e;
    logic [CW-1:0] mon_c;

    uart_tx_arbiter #(.BUSY_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_data0      (i_data0),
        .i_data1      (i_data1),
        .o_ack        (o_ack),
        .o_P_DATA     (o_P_DATA),
        .o_Data_Valid (o_Data_Valid),
        .i_busy       (i_busy),
        .o_grant_id   (o_grant_id),
        .o_active     (o_active),
        .o_err        (o_err),
        .o_frame_cnt  (o_frame_cnt),
        .o_dbg_state  (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_exp(input logic gid, input logic [7:0] data);
        return {(gid ? 2'b10 : 2'b01), gid, data};
    endfunction

    // Monitor: every load strobe and every frame-counter change must match the next expectation.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_cnt = '0;
        end else begin
            if (o_Data_Valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL load_unexpected actual=%0h required=none", {o_ack, o_grant_id, o_P_DATA});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("load", 32'({o_ack, o_grant_id, o_P_DATA}), 32'(mon_e));
                end
            end
            if (o_frame_cnt != prev_cnt) begin
                if (exp_cnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_cnt_unexpected actual=%0d required=%0d", o_frame_cnt, prev_cnt);
                end else begin
                    mon_c = exp_cnt_q.pop_front();
                    check("frame_cnt_step", 32'(o_frame_cnt), 32'(mon_c));
                end
                prev_cnt = o_frame_cnt;
            end
        end
    end

    task automatic wait_dv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_Data_Valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_load actual=timeout required=o_Data_Valid");
        end
    endtask

    // Transmitter model: busy rises dly cycles after the load and stays up len cycles.
    task automatic serve(input int dly, input int len, input logic [7:0] data);
        repeat (dly) @(negedge i_clk);
        i_busy = 1'b1;
        repeat (len) @(negedge i_clk);
        check("data_hold", 32'(o_P_DATA), 32'(data));
        check("active_busy", 32'(o_active), 32'd1);
        exp_frames = exp_frames + CW'(1);
        exp_cnt_q.push_back(exp_frames);
        i_busy = 1'b0;
        @(negedge i_clk);
        check("idle_after_frame", 32'({o_active, o_dbg_state}), 32'd0);
        check("frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
    endtask

    task automatic run_frame(input logic gid, input logic [7:0] data, input logic [1:0] req_after,
                             input int dly, input int len);
        bit ok;
        exp_q.push_back(mk_exp(gid, data));
        wait_dv(ok);
        i_req = req_after;
        if (ok) serve(dly, len, data);
    endtask

    initial begin
        bit ok;
        bit early;
        i_rst_n    = 1'b0;
        i_req      = 2'b00;
        i_data0    = 8'h00;
        i_data1    = 8'h00;
        i_busy     = 1'b0;
        exp_frames = '0;
        prev_cnt   = '0;
        repeat (2) @(negedge i_clk);
        check("rst_outputs", 32'({o_ack, o_P_DATA, o_Data_Valid, o_grant_id, o_active, o_err}), 32'd0);
        check("rst_cnt_state", 32'({o_frame_cnt, o_dbg_state}), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Single request: byte A5, busy 2 cycles after load for 11 cycles.
        i_data0 = 8'hA5;
        i_req   = 2'b01;
        run_frame(1'b0, 8'hA5, 2'b00, 2, 11);

        // Busy never rises: error exactly TMO cycles after entering WAIT_BUSY, no count.
        i_data1 = 8'h3C;
        i_req   = 2'b10;
        exp_q.push_back(mk_exp(1'b1, 8'h3C));
        wait_dv(ok);
        i_req = 2'b00;
        early = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge i_clk);
            if (o_err) early = 1'b1;
        end
        check("err_not_early", 32'(early), 32'd0);
        @(negedge i_clk);
        check("err_pulse", 32'(o_err), 32'd1);
        check("timeout_idle", 32'({o_active, o_dbg_state}), 32'd0);
        check("timeout_no_count", 32'(o_frame_cnt), 32'(exp_frames));
        @(negedge i_clk);
        check("err_one_cycle", 32'(o_err), 32'd0);

        // External busy held in IDLE blocks the load until it drops.
        i_busy  = 1'b1;
        i_data0 = 8'h77;
        i_req   = 2'b01;
        exp_q.push_back(mk_exp(1'b0, 8'h77));
        early = 1'b0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_Data_Valid) early = 1'b1;
        end
        check("busy_blocks_load", 32'(early), 32'd0);
        i_busy = 1'b0;
        @(negedge i_clk);
        check("load_after_busy", 32'(o_Data_Valid), 32'd1);
        i_req = 2'b00;
        serve(1, 3, 8'h77);

        // Reset while in WAIT_DONE abandons the frame.
        i_data0 = 8'h5A;
        i_req   = 2'b01;
        exp_q.push_back(mk_exp(1'b0, 8'h5A));
        wait_dv(ok);
        i_req = 2'b00;
        @(negedge i_clk);
        i_busy = 1'b1;
        repeat (2) @(negedge i_clk);
        check("in_wait_done", 32'(o_dbg_state), 32'd3);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 32'({o_ack, o_P_DATA, o_Data_Valid, o_grant_id, o_active, o_err}), 32'd0);
        check("async_rst_cnt", 32'({o_frame_cnt, o_dbg_state}), 32'd0);
        exp_frames = '0;
        i_busy     = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Tie held: grants alternate starting with requester 0; counter walks 1,2,3,0,1.
        i_data0 = 8'h11;
        i_data1 = 8'h22;
        i_req   = 2'b11;
        run_frame(1'b0, 8'h11, 2'b11, 1, 2);
        run_frame(1'b1, 8'h22, 2'b11, 1, 2);
        run_frame(1'b0, 8'h11, 2'b11, 1, 2);
        run_frame(1'b1, 8'h22, 2'b00, 1, 2);
        i_data0 = 8'h99;
        i_req   = 2'b01;
        run_frame(1'b0, 8'h99, 2'b00, 1, 1);

        repeat (3) @(negedge i_clk);
        check("final_cnt", 32'(o_frame_cnt), 32'd1);
        check("loads_drained", 32'(exp_q.size()), 32'd0);
        check("counts_drained", 32'(exp_cnt_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 16, max cycles to wait for i_busy rise after a load.
REQ-002 SHALL have parameter CNT_W, default 16, width of completed-frame counter.
REQ-003 SHALL have port i_clk  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req  input  2  per-requester byte request, held until acked.
REQ-006 SHALL have port i_data0  input  8  requester 0 byte, stable while i_req[0]=1.
REQ-007 SHALL have port i_data1  input  8  requester 1 byte, stable while i_req[1]=1.
REQ-008 SHALL have port o_ack  output  2  one-cycle accept pulse per requester.
REQ-009 SHALL have port o_P_DATA  output  8  byte to UART transmitter.
REQ-010 SHALL have port o_Data_Valid  output  1  one-cycle load strobe to transmitter.
REQ-011 SHALL have port i_busy  input  1  transmitter busy flag.
REQ-012 SHALL have port o_grant_id  output  1  index of requester owning the current frame.
REQ-013 SHALL have port o_active  output  1  high from load until frame end.
REQ-014 SHALL have port o_err  output  1  one-cycle pulse on busy timeout.
REQ-015 SHALL have port o_frame_cnt  output  CNT_W  completed frames, wraps to 0.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-017 IDLE: if i_busy=0 and i_req!=0 SHALL select winner, capture its byte into o_P_DATA, record o_grant_id, go LOAD next cycle; if i_busy=1 SHALL stay IDLE.
REQ-018 Arbitration SHALL be round-robin: on tie, winner is requester other than last_gnt; single request wins immediately.
REQ-019 LOAD (exactly one cycle): o_Data_Valid=1, o_ack[o_grant_id]=1, o_active=1; next state WAIT_BUSY.
REQ-020 Latency: request seen in IDLE at cycle N -> o_Data_Valid and o_ack at N+1.
REQ-021 WAIT_BUSY: on i_busy=1 SHALL go WAIT_DONE and clear timeout counter; otherwise increment counter.
REQ-022 WAIT_BUSY timeout: counter reaching BUSY_TIMEOUT with i_busy=0 SHALL pulse o_err one cycle, go IDLE, not increment o_frame_cnt; last_gnt still updated.
REQ-023 WAIT_DONE: on i_busy=0 SHALL increment o_frame_cnt (wrap 2^CNT_W-1 -> 0), set last_gnt=o_grant_id, go IDLE.
REQ-024 o_P_DATA SHALL stay constant from LOAD until return to IDLE.
REQ-025 o_active SHALL be 1 in LOAD, WAIT_BUSY, WAIT_DONE; 0 in IDLE.
REQ-026 Requests arriving outside IDLE SHALL be ignored until IDLE; no request lost while held.
REQ-027 Request dropped before ack SHALL simply not be granted; no error.
REQ-028 Minimum spacing SHALL be one IDLE cycle between frames (back-to-back frame returns to IDLE, then LOAD).

Reset
REQ-029 i_rst_n=0 SHALL immediately force IDLE, o_ack=0, o_Data_Valid=0, o_P_DATA=0, o_grant_id=0, o_active=0, o_err=0, o_frame_cnt=0, timeout counter=0, last_gnt=1 (requester 0 first).
REQ-030 Reset mid-frame SHALL abandon the frame without ack or count; first post-reset grant follows REQ-017.

Verification
REQ-031 Single: i_req=01, i_data0=0xA5, busy rises 2 cycles after load, holds 11 -> o_Data_Valid+o_ack=01 one cycle, o_P_DATA=0xA5, o_frame_cnt=1.
REQ-032 Tie: i_req=11 held, data0=0x11, data1=0x22 -> grants 0,1,0,1; bytes 0x11,0x22,0x11,0x22; o_frame_cnt=4.
REQ-033 Timeout: i_req=10, i_busy never rises -> o_err pulse exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY, o_frame_cnt=0, IDLE.
REQ-034 External busy: i_busy=1 in IDLE with i_req=01 -> no o_Data_Valid until i_busy=0, then load next cycle.
REQ-035 Reset mid-WAIT_DONE: assert i_rst_n=0 -> all outputs zero asynchronously, o_frame_cnt=0; after release i_req=11 grants requester 0.
REQ-036 Wrap: CNT_W=2, 5 completed frames -> o_frame_cnt sequence 1,2,3,0,1.
